// File: rtl/rf_sched_pkg.sv
// Shared definitions for the register-file allocation scheduler:
// default geometry, the name-count derivation and error-cause bit positions.
package rf_sched_pkg;

  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_NAME_WIDTH = 2;

  // Number of register-file names for a given name width.
  function automatic int num_names(input int name_width);
    return 1 << name_width;
  endfunction

  localparam int DEF_NUM_NAMES = num_names(DEF_NAME_WIDTH);

  typedef logic [DEF_NAME_WIDTH-1:0] name_t;
  typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;

  // Bit positions of the individual causes that raise the sticky ERR flag.
  localparam int ERR_FREE_UNALLOC = 0;  // free of a name that is not allocated
  localparam int ERR_FREE_DUP     = 1;  // second free of a name already pending
  localparam int ERR_OVERFLOW     = 2;  // allocation with every name outstanding
  localparam int ERR_CAUSES       = 3;

endpackage

// File: rtl/rf_alloc_sched_rr_arbiter.sv
// Round-robin priority pick over NUM_REQ requesters. The search starts at the
// internal pointer; the pointer moves past the winner only when advanced.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] next_ptr;
  int               cand_i;

  // First active requester at or after rr_ptr, wrapping mod NUM_REQ.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    any_req   = 1'b0;
    grant_idx = '0;
    cand_i    = 0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_i = (int'(rr_ptr) + k) % NUM_REQ;
      cand   = IDX_W'(cand_i);
      if (!any_req && req[cand]) begin
        any_req   = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // One-hot form of the winner and the pointer value just past it.
  always_comb begin
    grant_onehot = any_req ? (NUM_REQ'(1) << grant_idx) : '0;
    next_ptr     = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Pointer register: moves only when the grant is actually taken.
  always_ff @(posedge CLK) begin
    // NOTE: state is written with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/rf_alloc_sched.sv
// Scheduler in front of the bypass register file: round-robin arbitration of
// write reservations, out-of-order free capture with in-order replay on the
// free port, outstanding-name count and a sticky protocol-error flag.
module rf_alloc_sched
  import rf_sched_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int addr_width = DEF_ADDR_WIDTH,
  parameter int name_width = DEF_NAME_WIDTH
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*addr_width-1:0] REQ_ADDR,
  output logic [NUM_REQ-1:0]            REQ_GRANT,
  output logic [name_width-1:0]         GRANT_NAME,
  output logic [addr_width-1:0]         ALLOC_ADDR,
  output logic                          ALLOC_E,
  input  logic                          ALLOC_READY,
  input  logic [name_width-1:0]         NAME_IN,
  input  logic                          FREE_REQ,
  input  logic [name_width-1:0]         FREE_NAME,
  output logic [name_width-1:0]         W_F,
  output logic                          WFE,
  input  logic                          F_READY,
  output logic [name_width:0]           OUTSTANDING,
  output logic                          ERR
);

  localparam int NUM_NAMES = num_names(name_width);
  localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W     = name_width + 1;

  logic [NUM_REQ-1:0]    win_onehot;
  logic [IDX_W-1:0]      win_idx;
  logic                  any_req;

  logic [NUM_NAMES-1:0]  alloc_bm;
  logic [NUM_NAMES-1:0]  pend_bm;
  logic [name_width-1:0] own;
  logic [CNT_W-1:0]      cnt;
  logic                  err_q;

  logic                  alloc_e;
  logic                  wfe;
  logic                  retire;
  logic                  free_ok;
  logic                  cnt_inc;
  logic [ERR_CAUSES-1:0] err_vec;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .CLK          (CLK),
    .RST          (RST),
    .req          (REQ_VALID),
    .advance      (alloc_e),
    .grant_onehot (win_onehot),
    .grant_idx    (win_idx),
    .any_req      (any_req)
  );

  // Handshake decode: reservation, in-order retire and free-request checks.
  always_comb begin
    alloc_e = ALLOC_READY & any_req & ~RST;
    wfe     = pend_bm[own] & ~RST;
    retire  = wfe & F_READY;

    err_vec                   = '0;
    err_vec[ERR_FREE_UNALLOC] = FREE_REQ & ~alloc_bm[FREE_NAME];
    err_vec[ERR_FREE_DUP]     = FREE_REQ & pend_bm[FREE_NAME];
    err_vec[ERR_OVERFLOW]     = alloc_e & ~retire & (cnt == CNT_W'(NUM_NAMES));

    free_ok = FREE_REQ & ~err_vec[ERR_FREE_UNALLOC] & ~err_vec[ERR_FREE_DUP];
    // An allocation beyond the name count is flagged, not counted.
    cnt_inc = alloc_e & ~err_vec[ERR_OVERFLOW];
  end

  // Output drive; all register-file facing enables are forced low in reset.
  always_comb begin
    REQ_GRANT   = alloc_e ? win_onehot : '0;
    GRANT_NAME  = NAME_IN;
    ALLOC_ADDR  = REQ_ADDR[win_idx*addr_width +: addr_width];
    ALLOC_E     = alloc_e;
    W_F         = RST ? '0 : own;
    WFE         = wfe;
    OUTSTANDING = RST ? '0 : cnt;
    ERR         = err_q & ~RST;
  end

  // Name tracking state: allocation/pending bitmaps, replay pointer, count, error.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the bitmaps are explicitly cleared because a reset must drop every
      // pending free; they are flop vectors, not a RAM, so this is cheap.
      alloc_bm <= '0;
      pend_bm  <= '0;
      own      <= '0;
      cnt      <= '0;
      err_q    <= 1'b0;
    end else begin
      if (retire) begin
        alloc_bm[own] <= 1'b0;
        pend_bm[own]  <= 1'b0;
        own           <= own + 1'b1;
      end
      if (alloc_e) begin
        alloc_bm[NAME_IN] <= 1'b1;
      end
      if (free_ok) begin
        pend_bm[FREE_NAME] <= 1'b1;
      end
      case ({cnt_inc, retire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (|err_vec) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_alloc_sched.sv
// Directed bench for rf_alloc_sched: a vector table for arbitration and
// out-of-order free replay, then hand sequences for stall, error and wrap.
module tb_rf_alloc_sched;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  REQ_VALID;
  logic [9:0]  REQ_ADDR;
  logic [1:0]  REQ_GRANT;
  logic [1:0]  GRANT_NAME;
  logic [4:0]  ALLOC_ADDR;
  logic        ALLOC_E;
  logic        ALLOC_READY;
  logic [1:0]  NAME_IN;
  logic        FREE_REQ;
  logic [1:0]  FREE_NAME;
  logic [1:0]  W_F;
  logic        WFE;
  logic        F_READY;
  logic [2:0]  OUTSTANDING;
  logic        ERR;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  rf_alloc_sched #(.NUM_REQ(2), .addr_width(5), .name_width(2)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .REQ_VALID   (REQ_VALID),
    .REQ_ADDR    (REQ_ADDR),
    .REQ_GRANT   (REQ_GRANT),
    .GRANT_NAME  (GRANT_NAME),
    .ALLOC_ADDR  (ALLOC_ADDR),
    .ALLOC_E     (ALLOC_E),
    .ALLOC_READY (ALLOC_READY),
    .NAME_IN     (NAME_IN),
    .FREE_REQ    (FREE_REQ),
    .FREE_NAME   (FREE_NAME),
    .W_F         (W_F),
    .WFE         (WFE),
    .F_READY     (F_READY),
    .OUTSTANDING (OUTSTANDING),
    .ERR         (ERR)
  );

  typedef struct {
    logic [1:0] valid;
    logic       ready;
    logic [1:0] name_in;
    logic       free_req;
    logic [1:0] free_name;
    logic       f_ready;
    logic [1:0] grant;
    logic [1:0] gname;
    logic       chk_addr;
    logic [4:0] addr;
    logic       alloc_e;
    logic       wfe;
    logic [1:0] wf;
    logic [2:0] outst;
    logic       err;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(
    input logic [1:0] valid, input logic ready, input logic [1:0] name_in,
    input logic free_req, input logic [1:0] free_name, input logic f_ready,
    input logic [1:0] grant, input logic [1:0] gname, input logic chk_addr,
    input logic [4:0] addr, input logic alloc_e, input logic wfe,
    input logic [1:0] wf, input logic [2:0] outst, input logic err);
    vec_t v;
    v.valid = valid;  v.ready = ready;  v.name_in = name_in;
    v.free_req = free_req;  v.free_name = free_name;  v.f_ready = f_ready;
    v.grant = grant;  v.gname = gname;  v.chk_addr = chk_addr;  v.addr = addr;
    v.alloc_e = alloc_e;  v.wfe = wfe;  v.wf = wf;  v.outst = outst;  v.err = err;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, settle, then let the caller check.
  task automatic step(input logic [1:0] v, input logic rdy, input logic [1:0] nm,
                      input logic fr, input logic [1:0] fn, input logic frdy);
    @(negedge CLK);
    REQ_VALID   = v;
    ALLOC_READY = rdy;
    NAME_IN     = nm;
    FREE_REQ    = fr;
    FREE_NAME   = fn;
    F_READY     = frdy;
    #1;
  endtask

  initial begin
    // requester 1 -> address 17, requester 0 -> address 9
    REQ_ADDR = {5'd17, 5'd9};

    //             valid rdy nm fr fn frdy | grant gnm chk addr ae wfe wf  out err
    vecs[0]  = mk(2'b11, 1, 0, 0, 0, 1,   2'b01, 0,  1,  9,   1, 0,  0,  0,  0);
    vecs[1]  = mk(2'b11, 1, 1, 0, 0, 1,   2'b10, 1,  1,  17,  1, 0,  0,  1,  0);
    vecs[2]  = mk(2'b01, 0, 2, 0, 0, 1,   2'b00, 2,  1,  9,   0, 0,  0,  2,  0);
    vecs[3]  = mk(2'b01, 0, 2, 0, 0, 1,   2'b00, 2,  1,  9,   0, 0,  0,  2,  0);
    vecs[4]  = mk(2'b01, 0, 2, 0, 0, 1,   2'b00, 2,  1,  9,   0, 0,  0,  2,  0);
    vecs[5]  = mk(2'b01, 1, 2, 0, 0, 1,   2'b01, 2,  1,  9,   1, 0,  0,  2,  0);
    vecs[6]  = mk(2'b11, 0, 3, 0, 0, 1,   2'b00, 3,  1,  17,  0, 0,  0,  3,  0);
    vecs[7]  = mk(2'b11, 0, 3, 0, 0, 1,   2'b00, 3,  1,  17,  0, 0,  0,  3,  0);
    vecs[8]  = mk(2'b00, 1, 3, 1, 2, 1,   2'b00, 3,  0,  0,   0, 0,  0,  3,  0);
    vecs[9]  = mk(2'b00, 1, 3, 1, 1, 1,   2'b00, 3,  0,  0,   0, 0,  0,  3,  0);
    vecs[10] = mk(2'b00, 1, 3, 1, 0, 1,   2'b00, 3,  0,  0,   0, 0,  0,  3,  0);
    vecs[11] = mk(2'b00, 1, 3, 0, 0, 1,   2'b00, 3,  0,  0,   0, 1,  0,  3,  0);
    vecs[12] = mk(2'b00, 1, 3, 0, 0, 1,   2'b00, 3,  0,  0,   0, 1,  1,  2,  0);
    vecs[13] = mk(2'b00, 1, 3, 0, 0, 1,   2'b00, 3,  0,  0,   0, 1,  2,  1,  0);
    vecs[14] = mk(2'b00, 1, 3, 0, 0, 1,   2'b00, 3,  0,  0,   0, 0,  3,  0,  0);

    // Reset with live requests: nothing may be granted or enabled.
    RST = 1'b1;
    REQ_VALID = 2'b11;  ALLOC_READY = 1'b1;  NAME_IN = 2'd0;
    FREE_REQ = 1'b0;  FREE_NAME = 2'd0;  F_READY = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("rst grant", 32'(REQ_GRANT), 32'(0));
    check("rst alloc_e", 32'(ALLOC_E), 32'(0));
    check("rst wfe", 32'(WFE), 32'(0));
    check("rst w_f", 32'(W_F), 32'(0));
    check("rst outstanding", 32'(OUTSTANDING), 32'(0));
    check("rst err", 32'(ERR), 32'(0));
    @(negedge CLK);
    RST = 1'b0;
    REQ_VALID = 2'b00;

    // Table: arbitration, stall with ALLOC_READY low, out-of-order free replay.
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].valid, vecs[i].ready, vecs[i].name_in,
           vecs[i].free_req, vecs[i].free_name, vecs[i].f_ready);
      check($sformatf("v%0d grant", i), 32'(REQ_GRANT), 32'(vecs[i].grant));
      check($sformatf("v%0d grant_name", i), 32'(GRANT_NAME), 32'(vecs[i].gname));
      if (vecs[i].chk_addr)
        check($sformatf("v%0d alloc_addr", i), 32'(ALLOC_ADDR), 32'(vecs[i].addr));
      check($sformatf("v%0d alloc_e", i), 32'(ALLOC_E), 32'(vecs[i].alloc_e));
      check($sformatf("v%0d wfe", i), 32'(WFE), 32'(vecs[i].wfe));
      check($sformatf("v%0d w_f", i), 32'(W_F), 32'(vecs[i].wf));
      check($sformatf("v%0d outstanding", i), 32'(OUTSTANDING), 32'(vecs[i].outst));
      check($sformatf("v%0d err", i), 32'(ERR), 32'(vecs[i].err));
    end

    // Free-port stall: own=3, allocate name 3, free it, hold F_READY low.
    step(2'b01, 1, 3, 0, 0, 0);
    check("stall alloc grant", 32'(REQ_GRANT), 32'(2'b01));
    check("stall w_f own3", 32'(W_F), 32'(3));
    step(2'b00, 1, 0, 1, 3, 0);
    check("stall free wfe latency", 32'(WFE), 32'(0));
    for (int k = 0; k < 3; k++) begin
      step(2'b00, 1, 0, 0, 0, 0);
      check($sformatf("stall%0d wfe", k), 32'(WFE), 32'(1));
      check($sformatf("stall%0d w_f", k), 32'(W_F), 32'(3));
      check($sformatf("stall%0d outstanding", k), 32'(OUTSTANDING), 32'(1));
    end
    // Release with a simultaneous allocation of the wrapped name 0.
    step(2'b01, 1, 0, 0, 0, 1);
    check("release wfe", 32'(WFE), 32'(1));
    check("release alloc_e", 32'(ALLOC_E), 32'(1));
    step(2'b00, 1, 0, 1, 0, 1);
    check("both outstanding", 32'(OUTSTANDING), 32'(1));
    check("own wrapped", 32'(W_F), 32'(0));
    check("free own no wfe yet", 32'(WFE), 32'(0));
    step(2'b00, 1, 0, 0, 0, 1);
    check("free own replay", 32'(WFE), 32'(1));
    step(2'b00, 1, 0, 0, 0, 1);
    check("after replay wfe", 32'(WFE), 32'(0));
    check("after replay w_f", 32'(W_F), 32'(1));
    check("after replay outstanding", 32'(OUTSTANDING), 32'(0));

    // Free of an unallocated name: sticky error, nothing becomes pending.
    step(2'b00, 1, 0, 1, 3, 1);
    check("bad free err before", 32'(ERR), 32'(0));
    for (int k = 0; k < 3; k++) begin
      step(2'b00, 1, 0, 0, 0, 1);
      check($sformatf("err sticky%0d", k), 32'(ERR), 32'(1));
      check($sformatf("err no wfe%0d", k), 32'(WFE), 32'(0));
    end
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("err in reset", 32'(ERR), 32'(0));
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("err after reset", 32'(ERR), 32'(0));
    check("w_f after reset", 32'(W_F), 32'(0));

    // Wrap: fill all four names, free in order, allocate again from name 0.
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 1, 2'(i), 0, 0, 1);
      check($sformatf("fill%0d grant", i), 32'(REQ_GRANT), (i % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("fill%0d name", i), 32'(GRANT_NAME), 32'(i));
      check($sformatf("fill%0d outstanding", i), 32'(OUTSTANDING), 32'(i));
    end
    for (int k = 0; k < 4; k++) begin
      step(2'b00, 1, 0, 1, 2'(k), 1);
      check($sformatf("drain%0d wfe", k), 32'(WFE), (k > 0) ? 32'd1 : 32'd0);
      check($sformatf("drain%0d w_f", k), 32'(W_F), (k > 0) ? 32'(k - 1) : 32'd0);
      check($sformatf("drain%0d outstanding", k), 32'(OUTSTANDING), (k == 0) ? 32'd4 : 32'(5 - k));
    end
    step(2'b00, 1, 0, 0, 0, 1);
    check("drain last w_f", 32'(W_F), 32'(3));
    check("drain last outstanding", 32'(OUTSTANDING), 32'(1));
    for (int i = 0; i < 4; i++) begin
      step(2'b01, 1, 2'(i), 0, 0, 1);
      check($sformatf("refill%0d alloc_e", i), 32'(ALLOC_E), 32'(1));
      check($sformatf("refill%0d w_f", i), 32'(W_F), 32'(0));
      check($sformatf("refill%0d outstanding", i), 32'(OUTSTANDING), 32'(i));
      check($sformatf("refill%0d err", i), 32'(ERR), 32'(0));
    end

    // One more allocation with every name outstanding and no free.
    step(2'b01, 1, 0, 0, 0, 1);
    check("overflow outstanding", 32'(OUTSTANDING), 32'(4));
    check("overflow err before", 32'(ERR), 32'(0));
    step(2'b00, 1, 0, 0, 0, 1);
    check("overflow err", 32'(ERR), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
